// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-8 demultiplexer family: channel count,
// select width, the default beat layout and a one-hot decode helper.
package demux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 32;

  // A beat as it travels through the buffer: destination plus payload.
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Turn a channel number into its one-hot valid pattern.
  function automatic logic [NUM_CH-1:0] onehot_dec(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] vec;
    vec = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic two-entry valid/ready skid buffer. The head entry drives the
// output; the skid entry catches the beat that arrives while the head is
// stalled, so in_ready can come straight from a register without losing
// throughput. Beats leave strictly in arrival order.
module skid_buf2 #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_beat,
  output logic out_valid,
  input  logic out_ready,
  output T     out_beat
);

  logic h_valid;
  logic s_valid;
  T     h_beat;
  T     s_beat;
  logic acc;
  logic drn;

  // Handshake qualifiers for this cycle: a beat enters on acc, the head leaves on drn.
  always_comb begin
    acc = in_valid & ~s_valid;
    drn = h_valid & out_ready;
  end

  // in_ready is the inverse of the skid flag, so it never depends on out_ready.
  assign in_ready  = ~s_valid;
  assign out_valid = h_valid;
  assign out_beat  = h_beat;

  // All buffer state; payload registers carry no reset since the valid flags qualify them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!h_valid || drn) begin
      if (s_valid) begin
        h_valid <= 1'b1;
        h_beat  <= s_beat;
        if (acc) begin
          s_valid <= 1'b1;
          s_beat  <= in_beat;
        end else begin
          s_valid <= 1'b0;
        end
      end else if (acc) begin
        h_valid <= 1'b1;
        h_beat  <= in_beat;
        s_valid <= 1'b0;
      end else begin
        h_valid <= 1'b0;
        s_valid <= 1'b0;
      end
    end else if (acc) begin
      s_valid <= 1'b1;
      s_beat  <= in_beat;
    end
  end

endmodule

// File: rtl/demux8_skid.sv
// Registered 1-to-8 demultiplexer with valid/ready flow control. A two-entry
// skid buffer holds beats in order; the head beat is presented on the single
// shared data bus and flagged on exactly one out_valid bit. A stalled head
// blocks everything behind it, which keeps global ordering intact.
module demux8_skid
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [WIDTH-1:0]  in_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [WIDTH-1:0]  out_data
);

  // Beat layout at the instance width; matches demux_pkg::beat_t at the default width.
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } wbeat_t;

  wbeat_t in_beat;
  wbeat_t head_beat;
  logic   head_valid;
  logic   head_ready;

  assign in_beat.sel  = in_sel;
  assign in_beat.data = in_data;

  skid_buf2 #(
    .T (wbeat_t)
  ) u_buf (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_beat   (in_beat),
    .out_valid (head_valid),
    .out_ready (head_ready),
    .out_beat  (head_beat)
  );

  // Only the channel the head targets can accept it; other ready bits are ignored.
  always_comb begin
    head_ready = out_ready[head_beat.sel];
  end

  // One-hot steering of the head beat; the payload bus is shared by all channels.
  always_comb begin
    out_valid = '0;
    if (head_valid) begin
      out_valid = onehot_dec(head_beat.sel);
    end
    out_data = head_beat.data;
  end

endmodule

// File: tb/tb_demux8_skid.sv
// Self-checking bench for demux8_skid: directed scenarios with literal
// expectations plus a long randomized run against a queue-based model.
module tb_demux8_skid;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_sel = '0;
  logic [31:0] in_data = '0;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = '0;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  demux8_skid #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of at most two beats.
  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
  } mbeat_t;

  mbeat_t q[$];
  bit     stalled = 0;
  logic [7:0]  stall_valid;
  logic [31:0] stall_data;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update on each edge: flush empties, else head leaves if its channel is ready,
  // and a new beat is taken when fewer than two beats were held.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      stalled = 0;
    end else if (flush) begin
      q.delete();
      stalled = 0;
    end else begin
      int n;
      bit take;
      mbeat_t b;
      n = q.size();
      take = in_valid && (n < 2);
      stalled = 0;
      if (n > 0) begin
        if (out_ready[q[0].sel]) begin
          void'(q.pop_front());
        end else begin
          stalled = 1;
          stall_valid = 8'(1) << q[0].sel;
          stall_data = q[0].data;
        end
      end
      if (take) begin
        b.sel = in_sel;
        b.data = in_data;
        q.push_back(b);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      logic [7:0] ev;
      ev = (q.size() > 0) ? (8'(1) << q[0].sel) : 8'h00;
      checkOutput("model in_ready", 32'(in_ready), (q.size() < 2) ? 32'd1 : 32'd0);
      checkOutput("model out_valid", 32'(out_valid), 32'(ev));
      if (q.size() > 0) checkOutput("model out_data", out_data, q[0].data);
      checkOutput("onehot out_valid", 32'($onehot0(out_valid)), 32'd1);
      if (stalled) begin
        checkOutput("stall out_valid", 32'(out_valid), 32'(stall_valid));
        checkOutput("stall out_data", out_data, stall_data);
      end
    end
  end

  // Advance one clock; outputs are settled when this returns.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] s, input logic [31:0] d,
                               input logic [7:0] rdy, input logic fl);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 8'h00, 0);
    resetn = 0;
    repeat (2) cycle();
    checkOutput("reset out_valid", 32'(out_valid), 32'h00);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    resetn = 1;
    cycle();

    // Streaming: one beat per cycle to channels 0..7
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 3'(i), 32'hA0 + 32'(i), 8'hFF, 0);
      cycle();
      checkOutput($sformatf("stream%0d valid", i), 32'(out_valid), 32'(8'(1) << i));
      checkOutput($sformatf("stream%0d data", i), out_data, 32'hA0 + 32'(i));
      checkOutput($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
    end
    applyStimulus(0, 0, 0, 8'hFF, 0);
    cycle();
    checkOutput("stream drained", 32'(out_valid), 32'h00);

    // Backpressure
    applyStimulus(1, 3, 32'h11, 8'h00, 0);
    cycle();
    checkOutput("bp1 valid", 32'(out_valid), 32'h08);
    checkOutput("bp1 in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1, 5, 32'h22, 8'h00, 0);
    cycle();
    checkOutput("bp2 in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1, 6, 32'h33, 8'h00, 0);
    cycle();
    checkOutput("bp3 held in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp3 data", out_data, 32'h11);
    applyStimulus(1, 6, 32'h33, 8'h08, 0);
    cycle();
    checkOutput("bp4 valid", 32'(out_valid), 32'h20);
    checkOutput("bp4 data", out_data, 32'h22);
    checkOutput("bp4 in_ready", 32'(in_ready), 32'd1);
    cycle();
    checkOutput("bp5 in_ready", 32'(in_ready), 32'd0);
    applyStimulus(0, 0, 0, 8'hFF, 0);
    cycle();
    checkOutput("bp6 valid", 32'(out_valid), 32'h40);
    checkOutput("bp6 data", out_data, 32'h33);
    cycle();
    checkOutput("bp7 valid", 32'(out_valid), 32'h00);

    // Head-of-line blocking
    applyStimulus(1, 2, 32'h2, 8'h10, 0);
    cycle();
    applyStimulus(1, 4, 32'h4, 8'h10, 0);
    cycle();
    applyStimulus(0, 0, 0, 8'h10, 0);
    repeat (2) begin
      cycle();
      checkOutput("hol valid", 32'(out_valid), 32'h04);
      checkOutput("hol data", out_data, 32'h2);
    end
    applyStimulus(0, 0, 0, 8'hFF, 0);
    cycle();
    checkOutput("hol release valid", 32'(out_valid), 32'h10);
    checkOutput("hol release data", out_data, 32'h4);
    cycle();
    checkOutput("hol empty", 32'(out_valid), 32'h00);

    // Flush with two buffered beats and a beat offered
    applyStimulus(1, 1, 32'h55, 8'h00, 0);
    cycle();
    applyStimulus(1, 2, 32'h66, 8'h00, 0);
    cycle();
    applyStimulus(1, 7, 32'h77, 8'h00, 1);
    cycle();
    checkOutput("flush valid", 32'(out_valid), 32'h00);
    checkOutput("flush in_ready", 32'(in_ready), 32'd1);
    // Flush with a beat accepted in the same cycle
    applyStimulus(1, 3, 32'h88, 8'h00, 0);
    cycle();
    applyStimulus(1, 4, 32'h99, 8'h00, 1);
    cycle();
    checkOutput("flush acc valid", 32'(out_valid), 32'h00);
    applyStimulus(0, 0, 0, 8'hFF, 0);
    cycle();
    checkOutput("flush after valid", 32'(out_valid), 32'h00);

    // Reset mid-stream with beats buffered
    applyStimulus(1, 1, 32'hC1, 8'h00, 0);
    cycle();
    applyStimulus(1, 2, 32'hC2, 8'h00, 0);
    cycle();
    resetn = 0;
    #1;
    checkOutput("midreset valid", 32'(out_valid), 32'h00);
    checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
    cycle();
    applyStimulus(0, 0, 0, 8'hFF, 0);
    resetn = 1;
    cycle();
    checkOutput("postreset valid", 32'(out_valid), 32'h00);

    // Randomized run
    for (int c = 0; c < 10000; c++) begin
      applyStimulus(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)), $urandom(),
                    8'($urandom() | $urandom()), ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
      cycle();
    end
    applyStimulus(0, 0, 0, 8'hFF, 0);
    repeat (4) cycle();
    checkOutput("final empty", 32'(out_valid), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
